hdmi_pixel_packer: RTL and testbench

- Capture stage sitting directly behind the HDMI receiver's parallel bus (hdmi_data/hs/vs/de) and in front of the pixel AXI write path into DDR.
- Runs in the hdmi_clk domain. Frames capture on vsync, packs 24-bit RGB pixels densely into 32-bit words (4 pixels per 3 words) and buffers them in a small FIFO.
- Emits the words as a valid/ready stream marked with start-of-frame and end-of-line flags for the downstream AXI writer.

---
 rtl/hdmi_pixel_packer.sv | 246 ++++++++++++++++++++++++
 tb/tb_hdmi_pixel_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pixel_packer.sv
// Captures HDMI RGB frames, packs 4 pixels into 3 words and streams them out through a small FWFT FIFO.
// Define HDMI_PACKER_STATS_EN to build the width/height/frame counters; otherwise those outputs read 0.
module hdmi_pixel_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [23:0]      hdmi_data,
    input  logic             hdmi_hs,
    input  logic             hdmi_vs,
    input  logic             hdmi_de,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             m_user,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             clear_ovf_in,
    output logic             overflow_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] frame_count_o,
    output logic [CNT_W-1:0] height_o,
    output logic [CNT_W-1:0] width_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
    state_t state_reg, state_next;

    logic [23:0] data_reg;
    logic        de_reg, vs_reg, de_prev_reg, vs_prev_reg;
    logic        vs_rise, vs_fall, de_fall;
    logic        unused_hs;

    assign unused_hs = hdmi_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg    <= '0;
            de_reg      <= 1'b0;
            vs_reg      <= 1'b0;
            de_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
        end else begin
            data_reg    <= hdmi_data;
            de_reg      <= hdmi_de;
            vs_reg      <= hdmi_vs;
            de_prev_reg <= de_reg;
            vs_prev_reg <= vs_reg;
        end
    end

    assign vs_rise = vs_reg & ~vs_prev_reg;
    assign vs_fall = ~vs_reg & vs_prev_reg;
    assign de_fall = ~de_reg & de_prev_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable_in) state_next = WAIT_VS;
            WAIT_VS: if (!enable_in) state_next = IDLE;
                     else if (vs_rise) state_next = ACTIVE;
            ACTIVE:  if (vs_fall) state_next = enable_in ? WAIT_VS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic enter_active, in_active, pixel, line_end;
    assign enter_active = (state_reg == WAIT_VS) && (state_next == ACTIVE);
    assign in_active    = (state_reg == ACTIVE);
    assign pixel        = in_active && de_reg;
    assign line_end     = in_active && de_fall;
    assign busy_o       = in_active;

    // acc_reg carries the not-yet-emitted bytes of the current pixel group, right-aligned
    logic [1:0]  phase_reg, phase_next;
    logic [23:0] acc_reg, acc_next;
    logic        word_done;
    logic [31:0] word;

    always_comb begin
        phase_next = phase_reg;
        acc_next   = acc_reg;
        word_done  = 1'b0;
        word       = '0;
        if (enter_active || line_end) begin
            phase_next = 2'd0;
        end else if (pixel) begin
            phase_next = phase_reg + 2'd1;
            case (phase_reg)
                2'd0: acc_next = data_reg;
                2'd1: begin
                    word      = {data_reg[7:0], acc_reg};
                    word_done = 1'b1;
                    acc_next  = {8'h00, data_reg[23:8]};
                end
                2'd2: begin
                    word      = {data_reg[15:0], acc_reg[15:0]};
                    word_done = 1'b1;
                    acc_next  = {16'h0000, data_reg[23:16]};
                end
                default: begin
                    word      = {data_reg, acc_reg[7:0]};
                    word_done = 1'b1;
                    acc_next  = '0;
                end
            endcase
        end
    end

    logic        pend_valid_reg, pend_valid_next, flush_reg, flush_next, first_reg, first_next;
    logic [31:0] pend_data_reg, pend_data_next;
    logic        push, push_last;

    always_comb begin
        push            = 1'b0;
        push_last       = 1'b0;
        pend_valid_next = pend_valid_reg;
        pend_data_next  = pend_data_reg;
        flush_next      = 1'b0;
        if (flush_reg) begin
            push            = 1'b1;
            push_last       = 1'b1;
            pend_valid_next = 1'b0;
        end else if (enter_active) begin
            pend_valid_next = 1'b0;
        end else if (line_end) begin
            push      = pend_valid_reg;
            push_last = (phase_reg == 2'd0);
            if (phase_reg != 2'd0) begin
                pend_data_next  = {8'h00, acc_reg};
                pend_valid_next = 1'b1;
                flush_next      = 1'b1;
            end else begin
                pend_valid_next = 1'b0;
            end
        end else if (word_done) begin
            push            = pend_valid_reg;
            pend_data_next  = word;
            pend_valid_next = 1'b1;
        end
        first_next = enter_active ? 1'b1 : (push ? 1'b0 : first_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            phase_reg      <= 2'd0;
            acc_reg        <= '0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
            flush_reg      <= 1'b0;
            first_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            acc_reg        <= acc_next;
            pend_valid_reg <= pend_valid_next;
            pend_data_reg  <= pend_data_next;
            flush_reg      <= flush_next;
            first_reg      <= first_next;
        end
    end

    // The head entry stays in mem until popped; out_reg is its registered read-out.
    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr;
    logic [AW:0]   count_reg;
    logic [33:0]   out_reg;
    logic          valid_reg, ovf_reg, pop, full, wr_en, drop;

    assign pop     = valid_reg && m_ready;
    assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign rd_addr = rd_ptr_reg + AW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= {first_reg, push_last, pend_data_reg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            out_reg    <= '0;
            valid_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_addr;
            count_reg  <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);
            out_reg    <= mem[rd_addr];
            valid_reg  <= (count_reg - (AW+1)'(pop)) != '0;
            ovf_reg    <= drop ? 1'b1 : (clear_ovf_in ? 1'b0 : ovf_reg);
        end
    end

    assign m_data     = out_reg[31:0];
    assign m_last     = out_reg[32];
    assign m_user     = out_reg[33];
    assign m_valid    = valid_reg;
    assign overflow_o = ovf_reg;

`ifdef HDMI_PACKER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] pix_cnt_reg, line_cnt_reg, width_reg, height_reg, frames_reg, lines_now;

    assign lines_now = (line_end && line_cnt_reg != CNT_MAX) ? line_cnt_reg + CNT_W'(1) : line_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= '0;
            width_reg    <= '0;
            height_reg   <= '0;
            frames_reg   <= '0;
        end else if (enter_active) begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= '0;
        end else if (in_active) begin
            if (pixel && pix_cnt_reg != CNT_MAX) pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
            if (line_end) begin
                width_reg   <= pix_cnt_reg;
                pix_cnt_reg <= '0;
            end
            line_cnt_reg <= lines_now;
            if (vs_fall) begin
                height_reg   <= lines_now;
                frames_reg   <= frames_reg + CNT_W'(1);
                line_cnt_reg <= '0;
            end
        end
    end

    assign width_o       = width_reg;
    assign height_o      = height_reg;
    assign frame_count_o = frames_reg;
`else
    assign width_o       = '0;
    assign height_o      = '0;
    assign frame_count_o = '0;
`endif
endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Scoreboard bench for hdmi_pixel_packer: a byte-stream packing model fills an expected queue, a monitor pops on each transfer.
module tb_hdmi_pixel_packer;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable_in = 1'b0;
    logic [23:0]      hdmi_data = '0;
    logic             hdmi_hs = 1'b0, hdmi_vs = 1'b0, hdmi_de = 1'b0;
    logic [31:0]      m_data;
    logic             m_last, m_user, m_valid, m_ready;
    logic             clear_ovf_in = 1'b0;
    logic             overflow_o, busy_o;
    logic [CNT_W-1:0] frame_count_o, height_o, width_o;

    logic ready_ctl = 1'b1, rand_mode = 1'b0, rnd_bit = 1'b1;
    assign m_ready = rand_mode ? rnd_bit : ready_ctl;

    always #5 clk = ~clk;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    hdmi_pixel_packer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in),
        .hdmi_data(hdmi_data), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de),
        .m_data(m_data), .m_last(m_last), .m_user(m_user), .m_valid(m_valid), .m_ready(m_ready),
        .clear_ovf_in(clear_ovf_in), .overflow_o(overflow_o), .busy_o(busy_o),
        .frame_count_o(frame_count_o), .height_o(height_o), .width_o(width_o)
    );

    int checks = 0;
    int errors = 0;
    int n_words = 0;
    logic [33:0] exp_q[$];
    logic [23:0] line_px[$];
    logic cap = 1'b0, first_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the line is a little-endian byte stream B,G,R per pixel cut into 32-bit words, last word zero-padded.
    task automatic model_line();
        logic [7:0]  bytes[$];
        logic [31:0] w;
        int n;
        foreach (line_px[i]) begin
            bytes.push_back(line_px[i][7:0]);
            bytes.push_back(line_px[i][15:8]);
            bytes.push_back(line_px[i][23:16]);
        end
        n = bytes.size();
        for (int i = 0; i < n; i += 4) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (i + b < n) w[8*b +: 8] = bytes[i + b];
            exp_q.push_back({first_exp, (i + 4 >= n), w});
            first_exp = 1'b0;
        end
    endtask

    task automatic send_line();
        if (cap) model_line();
        foreach (line_px[i]) begin
            hdmi_de   = 1'b1;
            hdmi_data = line_px[i];
            tick();
        end
        hdmi_de   = 1'b0;
        hdmi_data = '0;
        tick();
        hdmi_hs = 1'b1;
        tick();
        hdmi_hs = 1'b0;
        repeat (5) tick();
    endtask

    task automatic rand_line(input int n);
        line_px.delete();
        for (int i = 0; i < n; i++) line_px.push_back(24'($urandom()));
    endtask

    task automatic frame_begin(input logic capture);
        cap       = capture;
        first_exp = 1'b1;
        hdmi_vs   = 1'b1;
        repeat (4) tick();
    endtask

    task automatic frame_end();
        repeat (3) tick();
        hdmi_vs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            tick();
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && m_valid && m_ready) begin
            n_words++;
            $display("word %0d data=0x%08h last=%0b user=%0b", n_words, m_data, m_last, m_user);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h last=%0b user=%0b expected no word", m_data, m_last, m_user);
            end else begin
                e = exp_q.pop_front();
                check("word", {m_user, m_last, m_data}, e);
            end
        end
    end

    initial begin
        int exp_w, exp_h, exp_f, n_frames;

        // reset state
        repeat (3) tick();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_flags", {m_last, m_user}, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_counts", {frame_count_o, height_o, width_o}, 0);
        rst_n = 1'b1;
        tick();

        // directed 4- and 5-pixel lines
        enable_in = 1'b1;
        tick();
        frame_begin(1'b1);
        check("busy_active", busy_o, 1);
        line_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        send_line();
        frame_end();
        drain();
        frame_begin(1'b1);
        line_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDDEEFF};
        send_line();
        frame_end();
        drain();

        // overflow: 64 pixels with consumer stalled keeps the first FIFO_DEPTH words
        ready_ctl = 1'b0;
        frame_begin(1'b1);
        rand_line(64);
        model_line();
        cap = 1'b0;
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        send_line();
        frame_end();
        check("ovf_set", overflow_o, 1);
        check("ovf_valid_held", m_valid, 1);
        ready_ctl = 1'b1;
        drain();
        check("ovf_empty_after_drain", m_valid, 0);
        clear_ovf_in = 1'b1;
        tick();
        clear_ovf_in = 1'b0;
        tick();
        check("ovf_cleared", overflow_o, 0);

        // enable raised mid-frame: nothing until the next vsync rise
        enable_in = 1'b0;
        tick();
        frame_begin(1'b0);
        rand_line(7);
        send_line();
        enable_in = 1'b1;
        rand_line(8);
        send_line();
        check("busy_wait_vs", busy_o, 0);
        frame_end();
        // enable dropped mid-frame: current frame completes
        frame_begin(1'b1);
        rand_line(6);
        send_line();
        enable_in = 1'b0;
        rand_line(9);
        send_line();
        check("busy_finishing", busy_o, 1);
        frame_end();
        check("busy_idle", busy_o, 0);
        frame_begin(1'b0);
        rand_line(5);
        send_line();
        frame_end();
        check("busy_idle_frame", busy_o, 0);
        drain();

        // randomized lines with random backpressure
        enable_in = 1'b1;
        tick();
        rand_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame_begin(1'b1);
            for (int l = 0; l < 4; l++) begin
                rand_line($urandom_range(0, 16));
                send_line();
                drain();
            end
            frame_end();
        end
        rand_mode = 1'b0;
        check("ovf_after_random", overflow_o, 0);

        // reset mid-line with words buffered
        ready_ctl = 1'b0;
        frame_begin(1'b1);
        cap = 1'b0;
        for (int i = 0; i < 9; i++) begin
            hdmi_de   = 1'b1;
            hdmi_data = 24'($urandom());
            tick();
        end
        check("valid_before_reset", m_valid, 1);
        rst_n     = 1'b0;
        hdmi_data = 24'($urandom());
        tick();
        exp_q.delete();
        check("midrst_valid", m_valid, 0);
        check("midrst_data", m_data, 0);
        check("midrst_flags", {m_last, m_user, overflow_o, busy_o}, 0);
        check("midrst_counts", {frame_count_o, height_o, width_o}, 0);
        rst_n     = 1'b1;
        hdmi_de   = 1'b0;
        hdmi_vs   = 1'b0;
        hdmi_data = '0;
        ready_ctl = 1'b1;
        repeat (3) tick();
        frame_begin(1'b1);
        line_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        send_line();
        frame_end();
        drain();

        // statistics: two frames of 3 lines x 6 pixels after a fresh reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_frames = 0;
        exp_w = 0;
        exp_h = 0;
        for (int f = 0; f < 2; f++) begin
            frame_begin(1'b1);
            exp_h = 0;
            for (int l = 0; l < 3; l++) begin
                rand_line(6);
                exp_w = line_px.size();
                exp_h++;
                send_line();
            end
            frame_end();
            n_frames++;
            drain();
        end
        exp_f = n_frames;
`ifndef HDMI_PACKER_STATS_EN
        exp_w = 0;
        exp_h = 0;
        exp_f = 0;
`endif
        check("width", width_o, exp_w);
        check("height", height_o, exp_h);
        check("frame_count", frame_count_o, exp_f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
